// File: rtl/seq_pkg.sv
// Shared definitions for the recirculating query-sequence buffer.
package seq_pkg;

    // Default symbol width: one nucleotide base.
    localparam int SEQ_SYM_W = 2;

    // Base encodings used by the scoring array.
    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    // Buffer control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_READY  = 2'd2,
        ST_ROTATE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_ring_cell.sv
// One symbol register of the ring; updates on the falling clock edge.
module seq_ring_cell
    import seq_pkg::*;
#(
    parameter int SYM_W = SEQ_SYM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [SYM_W-1:0] d,
    output logic [SYM_W-1:0] q
);

    // Shift register stage with async clear.
    always_ff @(negedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/seq_ring_buffer.sv
// Recirculating query-sequence buffer: loads a variable-length sequence, then
// replays it a programmable number of times with stall, markers and done.
module seq_ring_buffer
    import seq_pkg::*;
#(
    parameter int SYM_W  = SEQ_SYM_W,
    parameter int DEPTH  = 128,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int PASS_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              stall,
    output logic [CNT_W-1:0]  len,
    output logic              out_valid,
    output logic [SYM_W-1:0]  out_sym,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_first,
    output logic              pass_done,
    output logic              done,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
    localparam logic [PASS_W-1:0] PONE    = PASS_W'(1);

    seq_state_e state, state_nxt;

    logic [CNT_W-1:0]              idx;
    logic [PASS_W-1:0]             pass_cnt;
    logic [PASS_W-1:0]             passes;
    logic [DEPTH-1:0][SYM_W-1:0]   ring_q;
    logic [DEPTH-1:0][SYM_W-1:0]   ring_d;
    logic [SYM_W-1:0]              tap;
    logic [SYM_W-1:0]              head;
    logic accept, go, step, idx_wrap, last_step, shift_en;

    // Clear overrides every other action, so it masks all event strobes.
    assign in_ready  = ((state == ST_IDLE) || (state == ST_LOAD)) && (len < DEPTH_C);
    assign accept    = in_valid && in_ready && !clear;
    assign go        = (state == ST_READY) && start && (num_passes != '0) && !clear;
    assign step      = (state == ST_ROTATE) && !stall && !clear;
    assign idx_wrap  = (idx == len - ONE);
    assign last_step = step && idx_wrap && (pass_cnt == passes - PONE);
    assign shift_en  = accept || step;

    // During replay the tap feeds back into the head, closing a ring of len cells;
    // cells beyond len-1 shift too but are never observed.
    assign head   = step ? tap : in_sym;
    assign ring_d = {ring_q[DEPTH-2:0], head};

    assign busy      = (state == ST_ROTATE);
    assign out_first = out_valid && (out_idx == '0);
    assign pass_done = out_valid && (out_idx == len - ONE);

    // Tap mux: the oldest loaded symbol sits at r[len-1].
    always_comb begin
        tap = ring_q[0];
        for (int i = 0; i < DEPTH; i++)
            if (CNT_W'(i) == len - ONE) tap = ring_q[i];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ring
        seq_ring_cell #(.SYM_W(SYM_W)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (shift_en),
            .d     (ring_d[i]),
            .q     (ring_q[i])
        );
    end

    // State register.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: load until last/full, hold, replay until final symbol.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_LOAD:
                if (accept)
                    state_nxt = (in_last || (len + ONE == DEPTH_C)) ? ST_READY : ST_LOAD;
            ST_READY:  if (go)        state_nxt = ST_ROTATE;
            ST_ROTATE: if (last_step) state_nxt = ST_READY;
            default:                  state_nxt = ST_IDLE;
        endcase
        if (clear) state_nxt = ST_IDLE;
    end

    // Length, replay counters and registered output stream.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            len       <= '0;
            idx       <= '0;
            pass_cnt  <= '0;
            passes    <= '0;
            out_sym   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (clear) begin
            len       <= '0;
            idx       <= '0;
            pass_cnt  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= step;
            done      <= last_step;
            if (accept) len <= len + ONE;
            if (go) begin
                passes   <= num_passes;
                pass_cnt <= '0;
                idx      <= '0;
            end
            if (step) begin
                out_sym <= tap;
                out_idx <= idx;
                if (idx_wrap) begin
                    idx      <= '0;
                    pass_cnt <= pass_cnt + PONE;
                end else begin
                    idx <= idx + ONE;
                end
            end
        end
    end

endmodule
